// File: rtl/serial_to_parallel_if.sv
// Handshake bundle between a serial bit source and the serial_to_parallel deserializer.
// SER2PAR_PARITY_CHECK_EN adds the parity_err_o status line.
interface serial_to_parallel_if #(
    parameter int N = 32
);
    logic         start_i;
    logic         bit_i;
    logic         bit_valid_i;
    logic [N-1:0] data_o;
    logic         valid_o;
    logic         busy_o;
    logic         abort_o;
`ifdef SER2PAR_PARITY_CHECK_EN
    logic         parity_err_o;

    modport master (
        output start_i, bit_i, bit_valid_i,
        input  data_o, valid_o, busy_o, abort_o, parity_err_o
    );
    modport slave (
        input  start_i, bit_i, bit_valid_i,
        output data_o, valid_o, busy_o, abort_o, parity_err_o
    );
`else
    modport master (
        output start_i, bit_i, bit_valid_i,
        input  data_o, valid_o, busy_o, abort_o
    );
    modport slave (
        input  start_i, bit_i, bit_valid_i,
        output data_o, valid_o, busy_o, abort_o
    );
`endif
endinterface

// File: rtl/serial_to_parallel.sv
// Framed serial-to-parallel deserializer: assembles N bits after start_i into data_o with a valid strobe.
// Optional trailing even-parity bit check enabled by SER2PAR_PARITY_CHECK_EN.
module serial_to_parallel #(
    parameter int N         = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_to_parallel_if.slave  bus
);
    localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     sr;
    logic [N-1:0]     sr_next;
    logic [N-1:0]     data_q;
    logic             valid_q;
    logic             busy_q;
    logic             abort_q;
`ifdef SER2PAR_PARITY_CHECK_EN
    logic             perr_q;
`endif

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur, input logic b);
        if (MSB_FIRST)
            return {cur[N-2:0], b};
        else
            return {b, cur[N-1:1]};
    endfunction

    always_comb begin
        sr_next = shift_in(sr, bus.bit_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
`ifdef SER2PAR_PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Bits presented alongside start_i belong to no frame yet.
                    if (bus.start_i) begin
                        state  <= SHIFT;
                        cnt    <= '0;
                        sr     <= '0;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    if (bus.start_i) begin
                        // A restart beats any bit arriving in the same cycle, even a final one.
                        state   <= SHIFT;
                        cnt     <= '0;
                        sr      <= '0;
                        abort_q <= 1'b1;
                    end else if (bus.bit_valid_i) begin
`ifdef SER2PAR_PARITY_CHECK_EN
                        if (state == PARITY) begin
                            data_q  <= sr;
                            perr_q  <= ^{sr, bus.bit_i};
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            sr <= sr_next;
                            if (cnt == LAST_BIT) begin
                                state <= PARITY;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
`else
                        sr <= sr_next;
                        if (cnt == LAST_BIT) begin
                            data_q  <= sr_next;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state   <= IDLE;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`endif
                    end
                end
            endcase
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
    assign bus.busy_o  = busy_q;
    assign bus.abort_o = abort_q;
`ifdef SER2PAR_PARITY_CHECK_EN
    assign bus.parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: MSB-first and LSB-first N=8 instances share one stimulus table.
module tb_serial_to_parallel;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    serial_to_parallel_if #(.N(8)) if_m ();
    serial_to_parallel_if #(.N(8)) if_l ();

    serial_to_parallel #(.N(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m.slave));
    serial_to_parallel #(.N(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l.slave));

    typedef struct {
        logic       start;
        logic       bv;
        logic       b;
        logic       ev;
        logic       eb;
        logic       ea;
        logic [7:0] dm;
        logic [7:0] dl;
        logic       ep;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic bv, input logic b);
        if_m.start_i = s;  if_m.bit_valid_i = bv;  if_m.bit_i = b;
        if_l.start_i = s;  if_l.bit_valid_i = bv;  if_l.bit_i = b;
    endtask

    task automatic add(input logic s, input logic bv, input logic b, input logic ev, input logic eb,
                       input logic ea, input logic [7:0] dm, input logic [7:0] dl, input logic ep);
        vec_t v;
        v.start = s; v.bv = bv; v.b = b; v.ev = ev; v.eb = eb; v.ea = ea;
        v.dm = dm; v.dl = dl; v.ep = ep;
        tbl.push_back(v);
    endtask

    // Eight consecutive MSB-first bits of w; when complete, the last one yields (w, exp_l).
    task automatic add_word(input logic [7:0] w, input logic [7:0] pm, input logic [7:0] pl,
                            input logic [7:0] exp_l, input logic complete, input logic pp);
        logic [7:0] wv;
        wv = w;
        for (int i = 7; i > 0; i--) add(1'b0, 1'b1, wv[i], 1'b0, 1'b1, 1'b0, pm, pl, pp);
        if (complete) add(1'b0, 1'b1, wv[0], 1'b1, 1'b0, 1'b0, w, exp_l, pp);
        else          add(1'b0, 1'b1, wv[0], 1'b0, 1'b1, 1'b0, pm, pl, pp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        drive(v.start, v.bv, v.b);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d valid", idx), 32'(if_m.valid_o), 32'(v.ev));
        chk($sformatf("v%0d busy", idx),  32'(if_m.busy_o),  32'(v.eb));
        chk($sformatf("v%0d abort", idx), 32'(if_m.abort_o), 32'(v.ea));
        chk($sformatf("v%0d data_msb", idx), 32'(if_m.data_o), 32'(v.dm));
        chk($sformatf("v%0d data_lsb", idx), 32'(if_l.data_o), 32'(v.dl));
        chk($sformatf("v%0d valid_lsb", idx), 32'(if_l.valid_o), 32'(v.ev));
`ifdef SER2PAR_PARITY_CHECK_EN
        chk($sformatf("v%0d parity_err", idx), 32'(if_m.parity_err_o), 32'(v.ep));
`endif
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset data", 32'(if_m.data_o), 32'h0);
        chk("reset valid", 32'(if_m.valid_o), 32'h0);
        chk("reset busy", 32'(if_m.busy_o), 32'h0);
        chk("reset abort", 32'(if_m.abort_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef SER2PAR_PARITY_CHECK_EN
        // Correct parity: 0xB2 has four ones, so the parity bit is 0.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        add_word(8'hB2, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b0);
        // Wrong parity bit flags an error but still delivers the word.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0);
        add_word(8'hB2, 8'hB2, 8'h4D, 8'h00, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b1);
        // Restart while waiting for the parity bit aborts the frame.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b1);
        add_word(8'h0F, 8'hB2, 8'h4D, 8'h00, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hB2, 8'h4D, 1'b1);
        add_word(8'h0F, 8'hB2, 8'h4D, 8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0F, 8'hF0, 1'b0);
`else
        // start with a bit_valid in IDLE: that bit must not count.
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        add_word(8'hB2, 8'h00, 8'h00, 8'h4D, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hB2, 8'h4D, 1'b0);
        // All ones with gaps; gap cycles carry bit_i=0 which must be ignored.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0);
        begin
            logic [11:0] gap_v;
            int nv;
            gap_v = 12'b1101_1100_1101;
            nv = 0;
            for (int i = 11; i >= 0; i--) begin
                if (gap_v[i]) nv++;
                if (nv == 8 && gap_v[i])
                    add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
                else
                    add(1'b0, gap_v[i], gap_v[i], 1'b0, 1'b1, 1'b0, 8'hB2, 8'h4D, 1'b0);
            end
        end
        // Abort after 5 bits, then a clean 0xA5 frame.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
        add_word(8'hA5, 8'hFF, 8'hFF, 8'hA5, 1'b1, 1'b0);
        // Restart together with the 8th bit: start wins, no word delivered.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b0);
        add_word(8'h3C, 8'hA5, 8'hA5, 8'h3C, 1'b1, 1'b0);
        // Then 4 bits of a new frame, interrupted by reset below.
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0);
`endif

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

`ifndef SER2PAR_PARITY_CHECK_EN
        // Asynchronous reset mid-frame clears outputs without waiting for a clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst data_msb", 32'(if_m.data_o), 32'h0);
        chk("async rst data_lsb", 32'(if_l.data_o), 32'h0);
        chk("async rst busy", 32'(if_m.busy_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            vec_t v;
            v.start = 1'b0; v.bv = 1'b1; v.b = 1'(i & 1); v.ev = 1'b0; v.eb = 1'b0; v.ea = 1'b0;
            v.dm = 8'h00; v.dl = 8'h00; v.ep = 1'b0;
            apply(v, 1000 + i);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
